// File: rtl/mem_arbiter.sv
// Round-robin arbiter between instruction fetch (port 0) and LSU (port 1) onto one
// memory port; one transaction in flight, response routed back to its issuer.
package core_pkg;
    localparam int Xlen     = 32;
    localparam int MaskBits = Xlen / 8;
endpackage

module mem_arbiter
    import core_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req0_valid_i,
    output logic                req0_ready_o,
    input  logic [Xlen-1:0]     req0_addr_i,
    input  logic [Xlen-1:0]     req0_wdata_i,
    input  logic [MaskBits-1:0] req0_wmask_i,
    output logic [Xlen-1:0]     req0_rdata_o,
    output logic                req0_rvalid_o,
    input  logic                req1_valid_i,
    output logic                req1_ready_o,
    input  logic [Xlen-1:0]     req1_addr_i,
    input  logic [Xlen-1:0]     req1_wdata_i,
    input  logic [MaskBits-1:0] req1_wmask_i,
    output logic [Xlen-1:0]     req1_rdata_o,
    output logic                req1_rvalid_o,
    output logic                mem_valid_o,
    input  logic                mem_ready_i,
    output logic [Xlen-1:0]     mem_addr_o,
    output logic [Xlen-1:0]     mem_wdata_o,
    output logic [MaskBits-1:0] mem_wmask_o,
    input  logic [Xlen-1:0]     mem_rdata_i,
    input  logic                mem_rvalid_i
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_q, last_d;
    logic [Xlen-1:0]     addr_q, addr_d;
    logic [Xlen-1:0]     wdata_q, wdata_d;
    logic [MaskBits-1:0] wmask_q, wmask_d;
    logic                winner;

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_d        = last_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wmask_d       = wmask_q;
        req0_ready_o  = 1'b0;
        req1_ready_o  = 1'b0;
        req0_rvalid_o = 1'b0;
        req1_rvalid_o = 1'b0;
        mem_valid_o   = 1'b0;
        // On a tie the port not granted last time wins; otherwise the lone requester.
        winner = (req0_valid_i && req1_valid_i) ? ~last_q : req1_valid_i;

        case (state_q)
            ST_IDLE: begin
                // Grants and responses are suppressed while reset is held so nothing is lost.
                if (!rst_i && (req0_valid_i || req1_valid_i)) begin
                    req0_ready_o = ~winner;
                    req1_ready_o = winner;
                    owner_d      = winner;
                    last_d       = winner;
                    addr_d       = winner ? req1_addr_i  : req0_addr_i;
                    wdata_d      = winner ? req1_wdata_i : req0_wdata_i;
                    wmask_d      = winner ? req1_wmask_i : req0_wmask_i;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mem_valid_o = 1'b1;
                if (mem_ready_i) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid_i && !rst_i) begin
                    req0_rvalid_o = ~owner_q;
                    req1_rvalid_o = owner_q;
                    state_d       = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
        end
    end

    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign mem_wmask_o  = wmask_q;
    assign req0_rdata_o = mem_rdata_i;
    assign req1_rdata_o = mem_rdata_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, directed multi-cycle sequences, and random
// traffic checked against a transaction-level model.
module tb_mem_arbiter;
    import core_pkg::*;

    logic                clk_i = 1'b0;
    logic                rst_i = 1'b1;
    logic                req0_valid_i = 1'b0, req1_valid_i = 1'b0;
    logic                req0_ready_o, req1_ready_o;
    logic [Xlen-1:0]     req0_addr_i = '0, req1_addr_i = '0;
    logic [Xlen-1:0]     req0_wdata_i = '0, req1_wdata_i = '0;
    logic [MaskBits-1:0] req0_wmask_i = '0, req1_wmask_i = '0;
    logic [Xlen-1:0]     req0_rdata_o, req1_rdata_o;
    logic                req0_rvalid_o, req1_rvalid_o;
    logic                mem_valid_o;
    logic                mem_ready_i = 1'b0;
    logic [Xlen-1:0]     mem_addr_o, mem_wdata_o;
    logic [MaskBits-1:0] mem_wmask_o;
    logic [Xlen-1:0]     mem_rdata_i = '0;
    logic                mem_rvalid_i = 1'b0;

    mem_arbiter dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_addr_i(req0_addr_i),
        .req0_wdata_i(req0_wdata_i), .req0_wmask_i(req0_wmask_i), .req0_rdata_o(req0_rdata_o),
        .req0_rvalid_o(req0_rvalid_o),
        .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_addr_i(req1_addr_i),
        .req1_wdata_i(req1_wdata_i), .req1_wmask_i(req1_wmask_i), .req1_rdata_o(req1_rdata_o),
        .req1_rvalid_o(req1_rvalid_o),
        .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o), .mem_rdata_i(mem_rdata_i),
        .mem_rvalid_i(mem_rvalid_i)
    );

    always #5 clk_i = ~clk_i;

    // Stimulus {v0,v1,mem_ready,mem_rvalid} and expected {ready0,ready1,mem_valid,rvalid0,rvalid1}.
    typedef struct packed {
        logic       v0, v1, mr, mrv;
        logic [4:0] exp;
    } vec_t;

    vec_t tbl [26];
    int   tests = 0, fails = 0;
    int   n_r0, n_r1, n_rv0, n_rv1;

    function automatic logic [4:0] ctl();
        return {req0_ready_o, req1_ready_o, mem_valid_o, req0_rvalid_o, req1_rvalid_o};
    endfunction

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic v0, input logic v1, input logic mr, input logic mrv, input logic rst);
        @(negedge clk_i);
        req0_valid_i = v0;
        req1_valid_i = v1;
        mem_ready_i  = mr;
        mem_rvalid_i = mrv;
        rst_i        = rst;
        #1;
        n_r0  += int'(req0_ready_o);
        n_r1  += int'(req1_ready_o);
        n_rv0 += int'(req0_rvalid_o);
        n_rv1 += int'(req1_rvalid_o);
    endtask

    task automatic clr();
        n_r0 = 0; n_r1 = 0; n_rv0 = 0; n_rv1 = 0;
    endtask

    // Random-phase requester state and transaction-level model.
    logic            rq_v [2];
    logic [Xlen-1:0] rq_a [2], rq_d [2];
    logic [3:0]      rq_m [2];
    logic            m_pend, m_hs, m_owner, m_last, w, any;
    logic [Xlen-1:0] m_a, m_d;
    logic [3:0]      m_m;
    logic [4:0]      e;

    initial begin
        tbl = '{
            9'b1100_10000, 9'b1110_00100, 9'b1101_00010,   // contention: 0
            9'b1100_01000, 9'b1110_00100, 9'b1101_00001,   // 1
            9'b1100_10000, 9'b1110_00100, 9'b1101_00010,   // 0
            9'b1100_01000, 9'b1010_00100, 9'b1001_00001,   // 1
            9'b1001_10000, 9'b0001_00100, 9'b0010_00100,   // idle + issue spurious rvalid
            9'b0000_00000, 9'b0001_00010, 9'b0001_00000,
            9'b1000_10000, 9'b0010_00100, 9'b0100_00000,   // late arrival of port 1
            9'b0101_00010, 9'b0100_01000, 9'b0010_00100,
            9'b0001_00001, 9'b0000_00000
        };
        clr();

        // Reset: no grant while reset held, then everything zero.
        cyc(0, 0, 0, 0, 1);
        cyc(1, 1, 0, 0, 1);
        chk("rst_no_ready", {req0_ready_o, req1_ready_o}, 2'b00);
        cyc(0, 0, 0, 0, 0);
        chk("rst_state", {ctl(), mem_addr_o, mem_wdata_o, mem_wmask_o}, '0);

        req0_addr_i = 32'h10;
        req1_addr_i = 32'h20;
        for (int i = 0; i < 26; i++) begin
            cyc(tbl[i].v0, tbl[i].v1, tbl[i].mr, tbl[i].mrv, 0);
            chk($sformatf("tbl%0d", i), ctl(), tbl[i].exp);
        end

        // Single read on port 1, ready on 2nd Issue cycle, rvalid 3 cycles after handshake.
        clr();
        req1_addr_i  = 32'h100;
        req1_wmask_i = 4'b0000;
        cyc(0, 1, 0, 0, 0);
        chk("rd_grant", {req0_ready_o, req1_ready_o}, 2'b01);
        cyc(0, 0, 0, 0, 0);
        chk("rd_issue", {mem_valid_o, mem_addr_o, mem_wmask_o}, {1'b1, 32'h100, 4'h0});
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        mem_rdata_i = 32'hDEADBEEF;
        cyc(0, 0, 0, 1, 0);
        chk("rd_resp", {req1_rvalid_o, req1_rdata_o}, {1'b1, 32'hDEADBEEF});
        cyc(0, 0, 0, 0, 0);
        chk("rd_pulses", {8'(n_r0), 8'(n_r1), 8'(n_rv0), 8'(n_rv1)}, {8'd0, 8'd1, 8'd0, 8'd1});

        // Write on port 0.
        clr();
        req0_addr_i  = 32'h8;
        req0_wdata_i = 32'h0000AB00;
        req0_wmask_i = 4'b0010;
        cyc(1, 0, 0, 0, 0);
        chk("wr_grant", {req0_ready_o, req1_ready_o}, 2'b10);
        cyc(0, 0, 0, 0, 0);
        chk("wr_issue1", {mem_valid_o, mem_addr_o, mem_wdata_o, mem_wmask_o}, {1'b1, 32'h8, 32'h0000AB00, 4'b0010});
        cyc(0, 0, 1, 0, 0);
        chk("wr_issue2", {mem_valid_o, mem_addr_o, mem_wdata_o, mem_wmask_o}, {1'b1, 32'h8, 32'h0000AB00, 4'b0010});
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        chk("wr_pulses", {8'(n_r0), 8'(n_r1), 8'(n_rv0), 8'(n_rv1)}, {8'd1, 8'd0, 8'd1, 8'd0});

        // Reset during Issue: mem_valid drops the cycle after.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        chk("rst_issue_hold", mem_valid_o, 1'b1);
        cyc(0, 0, 0, 0, 0);
        chk("rst_issue_drop", ctl(), 5'b00000);

        // Reset during Wait, then late rvalid must not be forwarded.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 0);
        chk("rst_wait_drop", ctl(), 5'b00000);
        req0_addr_i = 32'h44;
        cyc(1, 0, 0, 0, 0);
        chk("post_rst_grant", ctl(), 5'b10000);
        cyc(0, 0, 1, 0, 0);
        chk("post_rst_issue", {mem_valid_o, mem_addr_o}, {1'b1, 32'h44});
        cyc(0, 0, 0, 1, 0);
        chk("post_rst_resp", ctl(), 5'b00010);

        // Random traffic against the transaction model.
        cyc(0, 0, 0, 0, 1);
        m_pend = 1'b0; m_hs = 1'b0; m_owner = 1'b0; m_last = 1'b1;
        m_a = '0; m_d = '0; m_m = '0;
        for (int p = 0; p < 2; p++) begin
            rq_v[p] = 1'b0; rq_a[p] = '0; rq_d[p] = '0; rq_m[p] = '0;
        end
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_i);
            for (int p = 0; p < 2; p++) begin
                if (!rq_v[p] && $urandom_range(0, 2) == 0) begin
                    rq_v[p] = 1'b1;
                    rq_a[p] = $urandom;
                    rq_d[p] = $urandom;
                    rq_m[p] = 4'($urandom_range(0, 15));
                end
            end
            rst_i        = 1'b0;
            req0_valid_i = rq_v[0]; req0_addr_i = rq_a[0]; req0_wdata_i = rq_d[0]; req0_wmask_i = rq_m[0];
            req1_valid_i = rq_v[1]; req1_addr_i = rq_a[1]; req1_wdata_i = rq_d[1]; req1_wmask_i = rq_m[1];
            mem_ready_i  = 1'($urandom_range(0, 1));
            mem_rvalid_i = ($urandom_range(0, 3) == 0);
            mem_rdata_i  = $urandom;
            #1;
            any = rq_v[0] || rq_v[1];
            w   = (rq_v[0] && rq_v[1]) ? !m_last : rq_v[1];
            e   = '0;
            if (!m_pend && any) e[w ? 3 : 4] = 1'b1;
            if (m_pend && !m_hs) e[2] = 1'b1;
            if (m_pend && m_hs && mem_rvalid_i) e[m_owner ? 0 : 1] = 1'b1;
            chk("rand_ctl", ctl(), e);
            if (m_pend && !m_hs)
                chk("rand_mem", {mem_addr_o, mem_wdata_o, mem_wmask_o}, {m_a, m_d, m_m});
            chk("rand_rdata", {req0_rdata_o, req1_rdata_o}, {mem_rdata_i, mem_rdata_i});
            if (!m_pend && any) begin
                m_pend = 1'b1; m_hs = 1'b0; m_owner = w; m_last = w;
                m_a = rq_a[w]; m_d = rq_d[w]; m_m = rq_m[w];
                rq_v[w] = 1'b0;
            end else if (m_pend && !m_hs && mem_ready_i) begin
                m_hs = 1'b1;
            end else if (m_pend && m_hs && mem_rvalid_i) begin
                m_pend = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
